// File: rtl/ppu_bus_monitor.sv
// ppu_bus_monitor: conditions raw PPU CHR bus activity into clean one-clock
// events for mapper IRQ logic. It produces a filtered A12 rise, a CHR read
// strobe, and a nametable-fetch based scanline/frame tracker.
module ppu_bus_monitor #(
  parameter int LOW_MIN = 2,
  parameter int TIMEOUT = 3,
  parameter int MATCHES = 3
) (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic        enable_i,
  input  logic        ce_i,
  input  logic        ppu_ce_i,
  input  logic [13:0] chr_ain_i,
  input  logic        chr_read_i,
  output logic        a12_rise_o,
  output logic        chr_rd_strobe_o,
  output logic        scanline_pulse_o,
  output logic        frame_start_o,
  output logic        in_frame_o,
  output logic [7:0]  scanline_cnt_o
);

  localparam logic [3:0] LOW_MIN_C   = 4'(LOW_MIN);
  localparam logic [3:0] TIMEOUT_C   = 4'(TIMEOUT);
  // A repeat read seen with this many prior matches completes the run.
  localparam logic [2:0] MATCH_PRE_C = 3'(MATCHES - 2);

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_e;

  state_e      state_q, state_d;
  logic [7:0]  scanline_cnt_q, scanline_cnt_d;
  logic        old_a12_q, old_a12_d;
  logic [3:0]  low_cnt_q, low_cnt_d;
  logic [13:0] last_nt_q, last_nt_d;
  logic [2:0]  match_cnt_q, match_cnt_d;
  logic [3:0]  idle_cnt_q, idle_cnt_d;
  logic        a12_rise_q, a12_rise_d;
  logic        chr_rd_strobe_q, chr_rd_strobe_d;
  logic        scanline_pulse_q, scanline_pulse_d;
  logic        frame_start_q, frame_start_d;
  logic        ppu_rd;
  logic        detect;
  logic        timeout;

  // Next-state logic: A12 low-time filter, nametable run detector, idle timeout
  // and frame/scanline FSM. A disabled mapper forces every register to its
  // reset value.
  always_comb begin
    state_d          = state_q;
    scanline_cnt_d   = scanline_cnt_q;
    old_a12_d        = old_a12_q;
    low_cnt_d        = low_cnt_q;
    last_nt_d        = last_nt_q;
    match_cnt_d      = match_cnt_q;
    idle_cnt_d       = idle_cnt_q;
    a12_rise_d       = 1'b0;
    chr_rd_strobe_d  = 1'b0;
    scanline_pulse_d = 1'b0;
    frame_start_d    = 1'b0;
    ppu_rd           = ppu_ce_i && chr_read_i;
    detect           = 1'b0;
    timeout          = 1'b0;

    if (!enable_i) begin
      state_d        = IDLE;
      scanline_cnt_d = '0;
      old_a12_d      = 1'b0;
      low_cnt_d      = LOW_MIN_C;
      last_nt_d      = '0;
      match_cnt_d    = '0;
      idle_cnt_d     = '0;
    end else begin
      chr_rd_strobe_d = ppu_rd;

      if (ppu_ce_i && chr_ain_i[12] && !old_a12_q) begin
        a12_rise_d = (low_cnt_q >= LOW_MIN_C);
        low_cnt_d  = '0;
      end else if (ce_i && !old_a12_q && (low_cnt_q < LOW_MIN_C)) begin
        low_cnt_d = low_cnt_q + 4'd1;
      end
      if (ppu_ce_i) begin
        old_a12_d = chr_ain_i[12];
      end

      if (ppu_rd) begin
        idle_cnt_d = '0;
        if (chr_ain_i[13]) begin
          if (chr_ain_i == last_nt_q) begin
            if (match_cnt_q != 3'd7) begin
              match_cnt_d = match_cnt_q + 3'd1;
            end
            detect = (match_cnt_q == MATCH_PRE_C);
          end else begin
            match_cnt_d = '0;
            last_nt_d   = chr_ain_i;
          end
        end else begin
          match_cnt_d = '0;
        end
      end else if (ce_i && (idle_cnt_q != TIMEOUT_C)) begin
        idle_cnt_d = idle_cnt_q + 4'd1;
      end
      timeout = (idle_cnt_d == TIMEOUT_C);

      if (detect) begin
        scanline_pulse_d = 1'b1;
        if (state_q == IDLE) begin
          state_d        = IN_FRAME;
          scanline_cnt_d = '0;
          frame_start_d  = 1'b1;
        end else begin
          scanline_cnt_d = scanline_cnt_q + 8'd1;
        end
      end else if (timeout) begin
        state_d     = IDLE;
        match_cnt_d = '0;
      end
    end
  end

  // State and output registers with asynchronous reset.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q          <= IDLE;
      scanline_cnt_q   <= '0;
      old_a12_q        <= 1'b0;
      low_cnt_q        <= LOW_MIN_C;
      last_nt_q        <= '0;
      match_cnt_q      <= '0;
      idle_cnt_q       <= '0;
      a12_rise_q       <= 1'b0;
      chr_rd_strobe_q  <= 1'b0;
      scanline_pulse_q <= 1'b0;
      frame_start_q    <= 1'b0;
    end else begin
      state_q          <= state_d;
      scanline_cnt_q   <= scanline_cnt_d;
      old_a12_q        <= old_a12_d;
      low_cnt_q        <= low_cnt_d;
      last_nt_q        <= last_nt_d;
      match_cnt_q      <= match_cnt_d;
      idle_cnt_q       <= idle_cnt_d;
      a12_rise_q       <= a12_rise_d;
      chr_rd_strobe_q  <= chr_rd_strobe_d;
      scanline_pulse_q <= scanline_pulse_d;
      frame_start_q    <= frame_start_d;
    end
  end

  assign a12_rise_o       = a12_rise_q;
  assign chr_rd_strobe_o  = chr_rd_strobe_q;
  assign scanline_pulse_o = scanline_pulse_q;
  assign frame_start_o    = frame_start_q;
  assign in_frame_o       = (state_q == IN_FRAME);
  assign scanline_cnt_o   = scanline_cnt_q;

endmodule

// File: tb/tb_ppu_bus_monitor.sv
// tb_ppu_bus_monitor: directed scenarios plus randomized traffic, checked
// against a behavioural model of the monitor's event rules.
module tb_ppu_bus_monitor;

  localparam int LOW_MIN = 2;
  localparam int TIMEOUT = 3;
  localparam int MATCHES = 3;

  logic        clk = 1'b0;
  logic        rst;
  logic        en;
  logic        ce;
  logic        ppu;
  logic        rd;
  logic [13:0] addr;
  logic        a12_rise;
  logic        chr_rd_strobe;
  logic        scanline_pulse;
  logic        frame_start;
  logic        in_frame;
  logic [7:0]  scanline_cnt;

  int errors = 0;
  int checks = 0;

  // Behavioural model: counts of events since the relevant reference point.
  int          lowCes;
  bit          prevA12;
  logic [13:0] lastNt;
  int          repeatCnt;
  int          idleCes;
  bit          mInFrame;
  int          mLine;
  bit          eRise, eStrobe, eScan, eFrame;
  bit          ntToggle;

  ppu_bus_monitor #(.LOW_MIN(LOW_MIN), .TIMEOUT(TIMEOUT), .MATCHES(MATCHES)) dut (
    .clk_i           (clk),
    .reset_i         (rst),
    .enable_i        (en),
    .ce_i            (ce),
    .ppu_ce_i        (ppu),
    .chr_ain_i       (addr),
    .chr_read_i      (rd),
    .a12_rise_o      (a12_rise),
    .chr_rd_strobe_o (chr_rd_strobe),
    .scanline_pulse_o(scanline_pulse),
    .frame_start_o   (frame_start),
    .in_frame_o      (in_frame),
    .scanline_cnt_o  (scanline_cnt)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  function automatic void modelClear();
    lowCes    = LOW_MIN;
    prevA12   = 1'b0;
    lastNt    = '0;
    repeatCnt = 0;
    idleCes   = 0;
    mInFrame  = 1'b0;
    mLine     = 0;
    eRise     = 1'b0;
    eStrobe   = 1'b0;
    eScan     = 1'b0;
    eFrame    = 1'b0;
  endfunction

  function automatic void modelStep(input bit e, input bit c, input bit p, input bit r,
                                    input logic [13:0] a);
    bit detect;
    eRise  = 1'b0;
    eScan  = 1'b0;
    eFrame = 1'b0;
    detect = 1'b0;
    if (!e) begin
      modelClear();
      return;
    end
    eStrobe = p && r;
    if (p && a[12] && !prevA12) begin
      eRise  = (lowCes >= LOW_MIN);
      lowCes = 0;
    end else if (c && !prevA12) begin
      lowCes++;
    end
    if (p) prevA12 = a[12];
    if (p && r) begin
      idleCes = 0;
      if (a[13]) begin
        if (a == lastNt) begin
          repeatCnt++;
          detect = (repeatCnt == MATCHES - 1);
        end else begin
          repeatCnt = 0;
          lastNt    = a;
        end
      end else begin
        repeatCnt = 0;
      end
    end else if (c) begin
      idleCes++;
    end
    if (detect) begin
      eScan = 1'b1;
      if (!mInFrame) begin
        mInFrame = 1'b1;
        mLine    = 0;
        eFrame   = 1'b1;
      end else begin
        mLine = (mLine + 1) % 256;
      end
    end else if (idleCes >= TIMEOUT) begin
      mInFrame  = 1'b0;
      repeatCnt = 0;
    end
  endfunction

  function automatic logic [12:0] expVec();
    return {eRise, eStrobe, eScan, eFrame, mInFrame, 8'(mLine)};
  endfunction

  function automatic logic [12:0] obsVec();
    return {a12_rise, chr_rd_strobe, scanline_pulse, frame_start, in_frame, scanline_cnt};
  endfunction

  task automatic tick(input bit e, input bit c, input bit p, input bit r, input logic [13:0] a);
    en   = e;
    ce   = c;
    ppu  = p;
    rd   = r;
    addr = a;
    @(posedge clk);
    #1;
    modelStep(e, c, p, r, a);
  endtask

  task automatic doReset();
    en   = 1'b1;
    ce   = 1'b0;
    ppu  = 1'b0;
    rd   = 1'b0;
    addr = '0;
    rst  = 1'b1;
    modelClear();
    @(posedge clk);
    #3;
    rst = 1'b0;
    @(posedge clk);
    #1;
    modelStep(1'b1, 1'b0, 1'b0, 1'b0, 14'h0000);
  endtask

  // Runs n lines of three identical nametable reads, alternating addresses.
  task automatic runLines(input int n, output int pulses);
    logic [13:0] a;
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      ntToggle = !ntToggle;
      a = ntToggle ? 14'h2401 : 14'h2400;
      for (int k = 0; k < 3; k++) begin
        tick(1'b1, 1'b0, 1'b1, 1'b1, a);
        if (scanline_pulse === 1'b1) pulses++;
      end
    end
  endtask

  task automatic test_reset();
    int pulses;
    doReset();
    checks++;
    if (obsVec() !== 13'd0) begin
      errors++;
      $display("[TB] FAIL reset_outputs: got %h expected %h", obsVec(), 13'd0);
    end
    runLines(38, pulses);
    checks++;
    if (in_frame !== 1'b1 || scanline_cnt !== 8'd37) begin
      errors++;
      $display("[TB] FAIL reset_prefill: in_frame=%b cnt=%0d expected 1/37", in_frame, scanline_cnt);
    end
    rst = 1'b1;
    modelClear();
    #1;
    checks++;
    if (obsVec() !== 13'd0) begin
      errors++;
      $display("[TB] FAIL reset_async: got %h expected %h", obsVec(), 13'd0);
    end
    @(posedge clk);
    #1;
    checks++;
    if (obsVec() !== 13'd0) begin
      errors++;
      $display("[TB] FAIL reset_held: got %h expected %h", obsVec(), 13'd0);
    end
    rst = 1'b0;
  endtask

  task automatic test_a12_filter();
    doReset();
    tick(1'b1, 1'b0, 1'b1, 1'b0, 14'h1000);
    checks++;
    if (a12_rise !== 1'b1) begin
      errors++;
      $display("[TB] FAIL a12_first_after_reset: got %b expected 1", a12_rise);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0, 14'h0000);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 14'h0000);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 14'h1000);
    checks++;
    if (a12_rise !== 1'b0) begin
      errors++;
      $display("[TB] FAIL a12_short_low: got %b expected 0", a12_rise);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b0, 14'h0000);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 14'h0000);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 14'h0000);
    tick(1'b1, 1'b0, 1'b1, 1'b0, 14'h1000);
    checks++;
    if (a12_rise !== 1'b1) begin
      errors++;
      $display("[TB] FAIL a12_long_low: got %b expected 1", a12_rise);
    end
    tick(1'b1, 1'b0, 1'b0, 1'b0, 14'h1000);
    checks++;
    if (a12_rise !== 1'b0) begin
      errors++;
      $display("[TB] FAIL a12_pulse_width: got %b expected 0", a12_rise);
    end
    tick(1'b1, 1'b1, 1'b1, 1'b0, 14'h0000);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 14'h1000);
    checks++;
    if (obsVec() !== expVec()) begin
      errors++;
      $display("[TB] FAIL a12_ce_coincide: got %h expected %h", obsVec(), expVec());
    end
  endtask

  task automatic test_frame_detect();
    doReset();
    tick(1'b1, 1'b0, 1'b1, 1'b1, 14'h2400);
    tick(1'b1, 1'b0, 1'b1, 1'b1, 14'h2400);
    checks++;
    if (scanline_pulse !== 1'b0 || in_frame !== 1'b0 || chr_rd_strobe !== 1'b1) begin
      errors++;
      $display("[TB] FAIL detect_early: pulse=%b in_frame=%b strobe=%b expected 0/0/1",
               scanline_pulse, in_frame, chr_rd_strobe);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b1, 14'h2400);
    checks++;
    if ({frame_start, scanline_pulse, in_frame, scanline_cnt} !== {3'b111, 8'd0}) begin
      errors++;
      $display("[TB] FAIL detect_third: got fs=%b sp=%b if=%b cnt=%0d expected 1/1/1/0",
               frame_start, scanline_pulse, in_frame, scanline_cnt);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b1, 14'h2400);
    checks++;
    if (frame_start !== 1'b0 || scanline_pulse !== 1'b0 || in_frame !== 1'b1) begin
      errors++;
      $display("[TB] FAIL detect_fourth: fs=%b sp=%b if=%b expected 0/0/1",
               frame_start, scanline_pulse, in_frame);
    end
  endtask

  task automatic test_scanlines();
    int pulses;
    doReset();
    runLines(240, pulses);
    checks++;
    if (pulses != 240 || scanline_cnt !== 8'd239) begin
      errors++;
      $display("[TB] FAIL lines_240: pulses=%0d cnt=%0d expected 240/239", pulses, scanline_cnt);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0, 14'h0000);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 14'h0000);
    checks++;
    if (in_frame !== 1'b1) begin
      errors++;
      $display("[TB] FAIL timeout_early: in_frame=%b expected 1", in_frame);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0, 14'h0000);
    checks++;
    if (in_frame !== 1'b0 || scanline_cnt !== 8'd239) begin
      errors++;
      $display("[TB] FAIL timeout_drop: in_frame=%b cnt=%0d expected 0/239", in_frame, scanline_cnt);
    end
  endtask

  task automatic test_timeout_collision();
    int pulses;
    doReset();
    runLines(1, pulses);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 14'h0000);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 14'h0000);
    tick(1'b1, 1'b1, 1'b1, 1'b1, 14'h0100);
    checks++;
    if (in_frame !== 1'b1) begin
      errors++;
      $display("[TB] FAIL collide_stay: in_frame=%b expected 1", in_frame);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0, 14'h0000);
    tick(1'b1, 1'b1, 1'b0, 1'b0, 14'h0000);
    checks++;
    if (in_frame !== 1'b1) begin
      errors++;
      $display("[TB] FAIL collide_idle_cleared: in_frame=%b expected 1", in_frame);
    end
    tick(1'b1, 1'b1, 1'b0, 1'b0, 14'h0000);
    checks++;
    if (in_frame !== 1'b0) begin
      errors++;
      $display("[TB] FAIL collide_later_drop: in_frame=%b expected 0", in_frame);
    end
  endtask

  task automatic test_enable_clear();
    int pulses;
    doReset();
    runLines(5, pulses);
    tick(1'b0, 1'b1, 1'b1, 1'b1, 14'h2401);
    checks++;
    if (obsVec() !== 13'd0) begin
      errors++;
      $display("[TB] FAIL enable_clear: got %h expected %h", obsVec(), 13'd0);
    end
    tick(1'b1, 1'b0, 1'b1, 1'b1, 14'h2401);
    tick(1'b1, 1'b0, 1'b1, 1'b1, 14'h2401);
    tick(1'b1, 1'b0, 1'b1, 1'b1, 14'h2401);
    checks++;
    if (frame_start !== 1'b1 || scanline_cnt !== 8'd0) begin
      errors++;
      $display("[TB] FAIL enable_restart: fs=%b cnt=%0d expected 1/0", frame_start, scanline_cnt);
    end
  endtask

  task automatic test_random();
    logic [13:0] a;
    logic [13:0] prevAddr;
    bit e, c, p, r;
    doReset();
    prevAddr = 14'h2400;
    for (int i = 0; i < 4000; i++) begin
      e = ($urandom_range(0, 199) != 0);
      c = ($urandom_range(0, 2) == 0);
      p = ($urandom_range(0, 1) == 1);
      r = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 9) < 6) begin
        a = prevAddr;
      end else begin
        case ($urandom_range(0, 4))
          0:       a = 14'h2400;
          1:       a = 14'h2401;
          2:       a = 14'h23C0;
          3:       a = {2'b01, 12'($urandom)};
          default: a = {2'b00, 12'($urandom)};
        endcase
      end
      prevAddr = a;
      tick(e, c, p, r, a);
      checks++;
      if (obsVec() !== expVec()) begin
        errors++;
        $display("[TB] FAIL random_cycle_%0d: got %h expected %h", i, obsVec(), expVec());
      end
    end
  endtask

  initial begin
    rst      = 1'b1;
    en       = 1'b0;
    ce       = 1'b0;
    ppu      = 1'b0;
    rd       = 1'b0;
    addr     = '0;
    ntToggle = 1'b0;
    modelClear();
    test_reset();
    test_a12_filter();
    test_frame_detect();
    test_scanlines();
    test_timeout_collision();
    test_enable_clear();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
